wb_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 12 +
 rtl/wb_load_align.sv | 51 +++++
 rtl/wb_stage.sv | 109 ++++++++++
 tb/tb_wb_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: load-type encodings and architectural constants.
package mips_pkg;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_BU = 3'b010;
    localparam logic [2:0] LD_H  = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    localparam logic [4:0] GPR_ZERO = 5'd0;

endpackage

// File: rtl/wb_load_align.sv
// Big-endian load extraction and alignment check; purely combinational.
module wb_load_align
    import mips_pkg::*;
(
    input  logic [31:0] i_memdata,
    input  logic [2:0]  i_ldtype,
    input  logic [1:0]  i_byteoff,
    output logic [31:0] o_data,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte 0 is the most significant lane.
    always_comb begin
        w_byte = i_memdata[31:24];
        case (i_byteoff)
            2'd0: w_byte = i_memdata[31:24];
            2'd1: w_byte = i_memdata[23:16];
            2'd2: w_byte = i_memdata[15:8];
            2'd3: w_byte = i_memdata[7:0];
            default: w_byte = i_memdata[31:24];
        endcase
    end

    assign w_half = i_byteoff[1] ? i_memdata[15:0] : i_memdata[31:16];

    always_comb begin
        o_data     = i_memdata;
        o_misalign = 1'b0;
        case (i_ldtype)
            LD_B:  o_data = {{24{w_byte[7]}}, w_byte};
            LD_BU: o_data = {24'h000000, w_byte};
            LD_H: begin
                o_data     = {{16{w_half[15]}}, w_half};
                o_misalign = i_byteoff[0];
            end
            LD_HU: begin
                o_data     = {16'h0000, w_half};
                o_misalign = i_byteoff[0];
            end
            // LW and reserved codes
            default: begin
                o_data     = i_memdata;
                o_misalign = (i_byteoff != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB stage register, writeback source select and retired-instruction counter.
module wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic                in_regwrite,
    input  logic                in_memtoreg,
    input  logic                in_link,
    input  logic [4:0]          in_wraddr,
    input  logic [DW-1:0]       in_aluout,
    input  logic [DW-1:0]       in_memdata,
    input  logic [DW-1:0]       in_pc8,
    input  logic [2:0]          in_ldtype,
    input  logic [1:0]          in_byteoff,
    output logic [4:0]          wraddr,
    output logic [DW-1:0]       wrdata,
    output logic                wren,
    output logic                wb_valid,
    output logic                misalign,
    output logic [RETIRE_W-1:0] retire_cnt
);

    logic                r_valid;
    logic                r_regwrite;
    logic                r_memtoreg;
    logic                r_link;
    logic [4:0]          r_wraddr;
    logic [DW-1:0]       r_aluout;
    logic [DW-1:0]       r_memdata;
    logic [DW-1:0]       r_pc8;
    logic [2:0]          r_ldtype;
    logic [1:0]          r_byteoff;
    logic [RETIRE_W-1:0] r_retire_cnt;

    logic [DW-1:0]       w_ld_data;
    logic                w_ld_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_link     <= 1'b0;
            r_wraddr   <= 5'd0;
            r_aluout   <= '0;
            r_memdata  <= '0;
            r_pc8      <= '0;
            r_ldtype   <= 3'b000;
            r_byteoff  <= 2'b00;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
        end else if (!stall) begin
            r_valid    <= in_valid;
            r_regwrite <= in_regwrite;
            r_memtoreg <= in_memtoreg;
            r_link     <= in_link;
            r_wraddr   <= in_wraddr;
            r_aluout   <= in_aluout;
            r_memdata  <= in_memdata;
            r_pc8      <= in_pc8;
            r_ldtype   <= in_ldtype;
            r_byteoff  <= in_byteoff;
        end
    end

    // A flushed-but-unstalled instruction still leaves the stage, so flush does not gate this.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (r_valid && !stall) begin
            r_retire_cnt <= r_retire_cnt + RETIRE_W'(1);
        end
    end

    wb_load_align u_load_align (
        .i_memdata  (r_memdata),
        .i_ldtype   (r_ldtype),
        .i_byteoff  (r_byteoff),
        .o_data     (w_ld_data),
        .o_misalign (w_ld_misalign)
    );

    assign misalign = r_valid & r_memtoreg & w_ld_misalign;

    // link has priority over memtoreg when both are (illegally) set.
    always_comb begin
        if (r_link) begin
            wrdata = r_pc8;
        end else if (r_memtoreg) begin
            wrdata = w_ld_data;
        end else begin
            wrdata = r_aluout;
        end
    end

    assign wren       = r_valid & r_regwrite & ~misalign & (r_wraddr != GPR_ZERO);
    assign wraddr     = r_wraddr;
    assign wb_valid   = r_valid;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage, with a second narrow-counter instance for wrap checks.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_regwrite;
    logic        in_memtoreg;
    logic        in_link;
    logic [4:0]  in_wraddr;
    logic [31:0] in_aluout;
    logic [31:0] in_memdata;
    logic [31:0] in_pc8;
    logic [2:0]  in_ldtype;
    logic [1:0]  in_byteoff;

    logic [4:0]  wraddr;
    logic [31:0] wrdata;
    logic        wren;
    logic        wb_valid;
    logic        misalign;
    logic [31:0] retire_cnt;

    logic [4:0]  wraddr4;
    logic [31:0] wrdata4;
    logic        wren4;
    logic        wb_valid4;
    logic        misalign4;
    logic [3:0]  retire_cnt4;

    int          n_checks;
    int          n_errors;
    logic        m_valid;
    logic [31:0] exp_cnt;

    wb_stage #(.DW(32), .RETIRE_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_regwrite (in_regwrite),
        .in_memtoreg (in_memtoreg),
        .in_link     (in_link),
        .in_wraddr   (in_wraddr),
        .in_aluout   (in_aluout),
        .in_memdata  (in_memdata),
        .in_pc8      (in_pc8),
        .in_ldtype   (in_ldtype),
        .in_byteoff  (in_byteoff),
        .wraddr      (wraddr),
        .wrdata      (wrdata),
        .wren        (wren),
        .wb_valid    (wb_valid),
        .misalign    (misalign),
        .retire_cnt  (retire_cnt)
    );

    wb_stage #(.DW(32), .RETIRE_W(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_regwrite (in_regwrite),
        .in_memtoreg (in_memtoreg),
        .in_link     (in_link),
        .in_wraddr   (in_wraddr),
        .in_aluout   (in_aluout),
        .in_memdata  (in_memdata),
        .in_pc8      (in_pc8),
        .in_ldtype   (in_ldtype),
        .in_byteoff  (in_byteoff),
        .wraddr      (wraddr4),
        .wrdata      (wrdata4),
        .wren        (wren4),
        .wb_valid    (wb_valid4),
        .misalign    (misalign4),
        .retire_cnt  (retire_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic rw, input logic m2r, input logic lnk,
                          input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] md,
                          input logic [31:0] pc8, input logic [2:0] lt, input logic [1:0] bo);
        in_valid    = v;
        in_regwrite = rw;
        in_memtoreg = m2r;
        in_link     = lnk;
        in_wraddr   = wa;
        in_aluout   = alu;
        in_memdata  = md;
        in_pc8      = pc8;
        in_ldtype   = lt;
        in_byteoff  = bo;
    endtask

    // Bench-side occupancy model drives the expected retire count.
    task automatic step();
        if (m_valid && !stall) exp_cnt++;
        m_valid = flush ? 1'b0 : (stall ? m_valid : in_valid);
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  ld_type [10];
    logic [1:0]  ld_off  [10];
    logic [31:0] ld_exp  [10];

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_valid  = 1'b0;
        exp_cnt  = 0;
        stall    = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);

        ld_type[0] = 3'b001; ld_off[0] = 2'd0; ld_exp[0] = 32'hFFFFFF80;
        ld_type[1] = 3'b010; ld_off[1] = 2'd0; ld_exp[1] = 32'h00000080;
        ld_type[2] = 3'b001; ld_off[2] = 2'd2; ld_exp[2] = 32'h0000007F;
        ld_type[3] = 3'b011; ld_off[3] = 2'd2; ld_exp[3] = 32'h00007F01;
        ld_type[4] = 3'b100; ld_off[4] = 2'd0; ld_exp[4] = 32'h000080FF;
        ld_type[5] = 3'b000; ld_off[5] = 2'd0; ld_exp[5] = 32'h80FF7F01;
        ld_type[6] = 3'b001; ld_off[6] = 2'd1; ld_exp[6] = 32'hFFFFFFFF;
        ld_type[7] = 3'b010; ld_off[7] = 2'd3; ld_exp[7] = 32'h00000001;
        ld_type[8] = 3'b011; ld_off[8] = 2'd0; ld_exp[8] = 32'hFFFF80FF;
        ld_type[9] = 3'b111; ld_off[9] = 2'd0; ld_exp[9] = 32'h80FF7F01;

        #3;
        check("reset_wren", {31'b0, wren}, 32'd0);
        check("reset_valid", {31'b0, wb_valid}, 32'd0);
        check("reset_misalign", {31'b0, misalign}, 32'd0);
        check("reset_wraddr", {27'b0, wraddr}, 32'd0);
        check("reset_wrdata", wrdata, 32'd0);
        check("reset_cnt", retire_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU writeback
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h12345678, 32'h0, 32'h0, 3'b000, 2'b00);
        step();
        check("alu_wren", {31'b0, wren}, 32'd1);
        check("alu_wraddr", {27'b0, wraddr}, 32'd5);
        check("alu_wrdata", wrdata, 32'h12345678);
        check("alu_cnt0", retire_cnt, 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
        step();
        check("alu_cnt1", retire_cnt, 32'd1);
        check("bubble_wren", {31'b0, wren}, 32'd0);

        // Loads
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'hAAAA5555, 32'h80FF7F01, 32'h0,
                   ld_type[i], ld_off[i]);
            step();
            check($sformatf("load%0d_data", i), wrdata, ld_exp[i]);
            check($sformatf("load%0d_wren", i), {31'b0, wren}, 32'd1);
            check($sformatf("load%0d_cnt", i), retire_cnt, exp_cnt);
        end

        // Misaligned halfword and word
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h80FF7F01, 32'h0, 3'b011, 2'd1);
        step();
        check("lh_off1_mis", {31'b0, misalign}, 32'd1);
        check("lh_off1_wren", {31'b0, wren}, 32'd0);
        check("lh_off1_valid", {31'b0, wb_valid}, 32'd1);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h80FF7F01, 32'h0, 3'b000, 2'd2);
        step();
        check("lh_off1_retired", retire_cnt, exp_cnt);
        check("lw_off2_mis", {31'b0, misalign}, 32'd1);
        check("lw_off2_wren", {31'b0, wren}, 32'd0);
        // Same offset but ALU result: no misalignment
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h1, 32'h80FF7F01, 32'h0, 3'b000, 2'd2);
        step();
        check("alu_off2_mis", {31'b0, misalign}, 32'd0);
        check("alu_off2_wren", {31'b0, wren}, 32'd1);
        check("mis_retired", retire_cnt, exp_cnt);

        // Write to $0
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h55, 32'h0, 32'h0, 3'b000, 2'b00);
        step();
        check("r0_wren", {31'b0, wren}, 32'd0);
        check("r0_wraddr", {27'b0, wraddr}, 32'd0);

        // Link, and link overriding memtoreg
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 32'h0000DEAD, 32'h0, 32'h00400010, 3'b000, 2'b00);
        step();
        check("link_wrdata", wrdata, 32'h00400010);
        check("link_wren", {31'b0, wren}, 32'd1);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 32'h0000DEAD, 32'h80FF7F01, 32'h00400020,
               3'b001, 2'b00);
        step();
        check("link_m2r_wrdata", wrdata, 32'h00400020);

        // Stall holds the instruction and the counter
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'hCAFEF00D, 32'h0, 32'h0, 3'b000, 2'b00);
        step();
        check("pre_stall_cnt", retire_cnt, exp_cnt);
        stall = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h11111111, 32'h0, 32'h0, 3'b000, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d_wrdata", i), wrdata, 32'hCAFEF00D);
            check($sformatf("stall%0d_wraddr", i), {27'b0, wraddr}, 32'd7);
            check($sformatf("stall%0d_wren", i), {31'b0, wren}, 32'd1);
            check($sformatf("stall%0d_cnt", i), retire_cnt, exp_cnt);
        end
        // Flush with stall: retire counting follows stall, so no increment here
        flush = 1'b1;
        step();
        check("flush_stall_valid", {31'b0, wb_valid}, 32'd0);
        check("flush_stall_wren", {31'b0, wren}, 32'd0);
        check("flush_stall_cnt", retire_cnt, exp_cnt);
        // Flush without stall on a valid instruction counts it as retired
        flush = 1'b0;
        stall = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h4, 32'h0, 32'h0, 3'b000, 2'b00);
        step();
        flush = 1'b1;
        step();
        check("flush_valid", {31'b0, wb_valid}, 32'd0);
        check("flush_cnt", retire_cnt, exp_cnt);
        flush = 1'b0;

        // Mid-cycle async reset drops a held instruction
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h66, 32'h0, 32'h0, 3'b000, 2'b00);
        step();
        check("pre_rst_wren", {31'b0, wren}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_wren", {31'b0, wren}, 32'd0);
        check("midrst_valid", {31'b0, wb_valid}, 32'd0);
        check("midrst_cnt", retire_cnt, 32'd0);
        check("midrst_cnt4", {28'b0, retire_cnt4}, 32'd0);
        m_valid = 1'b0;
        exp_cnt = 0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // Retire 17 instructions; the 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 32'(i), 32'h0, 32'h0, 3'b000, 2'b00);
            step();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
        step();
        check("wrap_cnt32", retire_cnt, 32'd17);
        check("wrap_cnt4", {28'b0, retire_cnt4}, 32'd1);
        check("wrap_model", {28'b0, retire_cnt4}, {28'b0, exp_cnt[3:0]});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
